// File: rtl/tick_counter_div.sv
// Up/down counter advanced by a programmable prescaler tick, single clock domain.
// The prescaler issues a one-cycle enable instead of a derived clock.
module tick_counter_div #(
  parameter int WIDTH     = 4,
  parameter int DIV_WIDTH = 26,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_max,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  output logic [WIDTH-1:0]     counter_out,
  output logic                 tick,
  output logic                 tc
);

  localparam logic [WIDTH-1:0]     CNT_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     CNT_ZERO   = {WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] PRESC_ZERO = {DIV_WIDTH{1'b0}};

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     cnt_step_s;
  logic                 tick_q, tick_d;
  logic                 at_term_s;
  logic                 presc_wrap_s;

  assign at_term_s    = up_dn ? (cnt_q == CNT_ONES) : (cnt_q == CNT_ZERO);
  // >= rather than == so a lowered div_max still wraps on the next enabled edge
  assign presc_wrap_s = (presc_q >= div_max);

  // Value the counter takes when a tick fires
  always_comb begin
    cnt_step_s = cnt_q;
    if (at_term_s && SATURATE) begin
      cnt_step_s = cnt_q;
    end else if (up_dn) begin
      cnt_step_s = cnt_q + WIDTH'(1);
    end else begin
      cnt_step_s = cnt_q - WIDTH'(1);
    end
  end

  // Next-state: load beats freeze beats counting
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (load) begin
      cnt_d   = load_val;
      presc_d = PRESC_ZERO;
    end else if (!en) begin
      presc_d = presc_q;
    end else if (presc_wrap_s) begin
      presc_d = PRESC_ZERO;
      tick_d  = 1'b1;
      cnt_d   = cnt_step_s;
    end else begin
      presc_d = presc_q + DIV_WIDTH'(1);
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= PRESC_ZERO;
      cnt_q   <= CNT_ZERO;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign counter_out = cnt_q;
  assign tick        = tick_q;
  assign tc          = at_term_s;

endmodule
